alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, meaning cycles the ALU result needs for func 5 (MUL); legal range 1..63.
REQ-002 SHALL have parameter DIV_LAT, default 34, meaning cycles the ALU result needs for func 3 (DIV); legal range 1..63.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request can be accepted this cycle.
REQ-007 SHALL have ports req_src1, req_src2  input  64 each  operands.
REQ-008 SHALL have ports req_func, req_inner  input  4 each  ALU func_control / inner_control codes.
REQ-009 SHALL have port req_tag  input  5  requester tag, returned with result.
REQ-010 SHALL have port flush  input  1  abort in-flight and pending work.
REQ-011 SHALL have ports alu_src1, alu_src2  output  64 each; alu_func, alu_inner  output  4 each; registered drive to the ALU.
REQ-012 SHALL have port alu_result  input  64  combinational ALU result.
REQ-013 SHALL have port rsp_valid  output  1; rsp_ready  input  1; rsp_result  output  64; rsp_tag  output  5.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-016 SHALL drive req_ready = !flush && (IDLE || (DONE && rsp_ready)); combinational dependence on rsp_ready is intended.
REQ-017 SHALL, on accept (req_valid && req_ready), register operands, func, inner, tag into alu_*/tag regs and enter EXEC.
REQ-018 SHALL load latency counter on accept: MUL_LAT for func 5, DIV_LAT for func 3, 1 for every other code (0-2, 4, 6-15).
REQ-019 SHALL, in EXEC, decrement counter each cycle; at the edge where counter==1, capture alu_result into rsp_result and enter DONE.
REQ-020 SHALL give accept-to-rsp_valid latency of L+1 cycles (L=1: accept edge at end of cycle 0, rsp_valid high in cycle 2).
REQ-021 SHALL hold alu_* outputs stable for the whole EXEC period (multi-cycle path) and retain last values in IDLE/DONE.
REQ-022 SHALL assert rsp_valid exactly in DONE; rsp_result/rsp_tag stable while rsp_valid && !rsp_ready.
REQ-023 SHALL, in DONE with rsp_ready and no new accept, return to IDLE; with simultaneous accept, go directly to EXEC (back-to-back, one op per 2 cycles for L=1).
REQ-024 SHALL give flush priority over all events: next state IDLE, rsp_valid low next cycle, no response for aborted op, no accept in flush cycle.
REQ-025 SHALL not flag illegal func codes; result is whatever alu_result presents (0 for codes 8-15).

Reset
REQ-026 SHALL, on rst low, asynchronously set state IDLE, counter 0, alu_src1/alu_src2/rsp_result 0, alu_func/alu_inner 0, rsp_tag 0, rsp_valid 0, busy 0.
REQ-027 SHALL, on reset asserted mid-EXEC or mid-DONE, discard the operation; no response after release.
REQ-028 SHALL have req_ready 1 in the first cycle after rst release (absent flush).

Structure
REQ-029 SHALL place func codes (ADDER=0, SHIFT=1, COMPARE=2, DIV=3, LOGIC=4, MUL=5, AUIPC=6, LUI=7), FSM state encoding and 6-bit counter width in shared package alu_pkg.
REQ-030 SHALL use one sub-module alu_lat_counter: 6-bit loadable down-counter with load, value and last (==1) output.

Verification
REQ-031 SHALL cover: ADD src1=5, src2=7, tag=3, rsp_ready=1 -> rsp_valid in cycle 2 after accept, rsp_result=12, rsp_tag=3.
REQ-032 SHALL cover: MUL func 5, MUL_LAT=3 -> rsp_valid exactly 4 cycles after accept; req_ready low and alu_* stable throughout.
REQ-033 SHALL cover: DIV src1=100, src2=7 inner 0 -> rsp_result=14 after 35 cycles; rsp_ready held low 5 cycles -> result/tag stable, then back-to-back accept in release cycle.
REQ-034 SHALL cover: flush 10 cycles into DIV -> IDLE next cycle, no rsp_valid ever for that tag, following ADD returns correctly.
REQ-035 SHALL cover: rst low during DONE with rsp_valid=1 -> rsp_valid 0 immediately, all outputs at REQ-026 values.
REQ-036 SHALL cover: flush and req_valid in same IDLE cycle -> req_ready 0, request not accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU func codes, issue FSM encoding and latency counter width.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int c_cnt_w = 6;

    localparam logic [3:0] c_func_adder   = 4'd0;
    localparam logic [3:0] c_func_shift   = 4'd1;
    localparam logic [3:0] c_func_compare = 4'd2;
    localparam logic [3:0] c_func_div     = 4'd3;
    localparam logic [3:0] c_func_logic   = 4'd4;
    localparam logic [3:0] c_func_mul     = 4'd5;
    localparam logic [3:0] c_func_auipc   = 4'd6;
    localparam logic [3:0] c_func_lui     = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only MUL and DIV are multi-cycle; every other code settles in one cycle.
    function automatic logic [c_cnt_w-1:0] lat_for(
        input logic [3:0]         func,
        input logic [c_cnt_w-1:0] mul_lat,
        input logic [c_cnt_w-1:0] div_lat
    );
        case (func)
            c_func_mul: return mul_lat;
            c_func_div: return div_lat;
            default:    return c_cnt_w'(1);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_lat_counter.sv
// ============================================================================
// Module : alu_lat_counter
// Brief  : Loadable 6-bit down-counter; o_last flags a value of one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_lat_counter
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic [c_cnt_w-1:0] i_load_val,
    input  logic               i_dec,
    output logic [c_cnt_w-1:0] o_value,
    output logic               o_last
);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_cnt_w'(1);
        end
    end

    assign o_value = r_cnt;
    assign o_last  = (r_cnt == c_cnt_w'(1));

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module : alu_issue_ctrl
// Brief  : Issues one op at a time to a combinational ALU over a multi-cycle
//          path and returns the captured result with the requester tag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_src1,
    input  logic [63:0] req_src2,
    input  logic [3:0]  req_func,
    input  logic [3:0]  req_inner,
    input  logic [4:0]  req_tag,
    input  logic        flush,
    output logic [63:0] alu_src1,
    output logic [63:0] alu_src2,
    output logic [3:0]  alu_func,
    output logic [3:0]  alu_inner,
    input  logic [63:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic [4:0]  rsp_tag,
    output logic        busy
);

    localparam logic [c_cnt_w-1:0] c_mul_lat = c_cnt_w'(MUL_LAT);
    localparam logic [c_cnt_w-1:0] c_div_lat = c_cnt_w'(DIV_LAT);

    state_t             r_state;
    logic [63:0]        r_alu_src1;
    logic [63:0]        r_alu_src2;
    logic [3:0]         r_alu_func;
    logic [3:0]         r_alu_inner;
    logic [4:0]         r_rsp_tag;
    logic [63:0]        r_rsp_result;
    logic               r_rsp_valid;
    logic               r_busy;

    logic               w_accept;
    logic               w_cnt_last;
    logic [c_cnt_w-1:0] w_cnt_value;

    // A completing response may hand the slot straight to a new request.
    assign req_ready = !flush && ((r_state == ST_IDLE) ||
                                  ((r_state == ST_DONE) && rsp_ready));
    assign w_accept  = req_valid && req_ready;

    alu_lat_counter u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (flush),
        .i_load     (w_accept),
        .i_load_val (lat_for(req_func, c_mul_lat, c_div_lat)),
        .i_dec      (r_state == ST_EXEC),
        .o_value    (w_cnt_value),
        .o_last     (w_cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_alu_src1   <= '0;
            r_alu_src2   <= '0;
            r_alu_func   <= '0;
            r_alu_inner  <= '0;
            r_rsp_tag    <= '0;
            r_rsp_result <= '0;
            r_rsp_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_EXEC;
                        r_busy  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (w_cnt_last) begin
                        r_rsp_result <= alu_result;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_accept) begin
                            r_state <= ST_EXEC;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase

            // Operands stay frozen between accepts, giving the ALU a stable multi-cycle path.
            if (w_accept) begin
                r_alu_src1  <= req_src1;
                r_alu_src2  <= req_src2;
                r_alu_func  <= req_func;
                r_alu_inner <= req_inner;
                r_rsp_tag   <= req_tag;
            end
        end
    end

    assign alu_src1   = r_alu_src1;
    assign alu_src2   = r_alu_src2;
    assign alu_func   = r_alu_func;
    assign alu_inner  = r_alu_inner;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_tag    = r_rsp_tag;
    assign busy       = r_busy;

    logic w_unused;
    assign w_unused = ^w_cnt_value;

endmodule

`default_nettype wire
